// File: rtl/instruction_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_buffer
//  Description : Fetch-to-decode FIFO with first-word fall-through head,
//                full / early_full back-pressure and single-cycle flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [31:0]                in_instruction,
    input  logic [31:0]                in_pc,
    input  logic                       in_prediction,
    input  logic                       in_uses_rs1,
    input  logic                       in_uses_rs2,
    input  logic                       in_uses_rd,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       valid,
    output logic [31:0]                out_instruction,
    output logic [31:0]                out_pc,
    output logic                       out_prediction,
    output logic                       out_uses_rs1,
    output logic                       out_uses_rs2,
    output logic                       out_uses_rd,
    output logic                       full,
    output logic                       early_full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
        logic        rs1;
        logic        rs2;
        logic        rd;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            push_ok;
    logic            pop_ok;
    entry_t          in_entry;
    entry_t          head;

    assign in_entry = '{instr: in_instruction, pc: in_pc, pred: in_prediction,
                        rs1: in_uses_rs1, rs2: in_uses_rs2, rd: in_uses_rd};

    assign valid      = (count_q != '0);
    assign full       = (count_q == CW'(DEPTH));
    assign early_full = (count_q >= CW'(DEPTH - 1));
    assign count      = count_q;

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = pop & valid;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && push_ok) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    assign head            = mem_q[rd_ptr_q];
    assign out_instruction = head.instr;
    assign out_pc          = head.pc;
    assign out_prediction  = head.pred;
    assign out_uses_rs1    = head.rs1;
    assign out_uses_rs2    = head.rs2;
    assign out_uses_rd     = head.rd;

endmodule
`default_nettype wire

// File: tb/tb_instruction_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_buffer
//  Description : Vector table plus queue scoreboard for instruction_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          push;
    logic [31:0]   in_instruction;
    logic [31:0]   in_pc;
    logic          in_prediction;
    logic          in_uses_rs1;
    logic          in_uses_rs2;
    logic          in_uses_rd;
    logic          pop;
    logic          flush;
    logic          valid;
    logic [31:0]   out_instruction;
    logic [31:0]   out_pc;
    logic          out_prediction;
    logic          out_uses_rs1;
    logic          out_uses_rs2;
    logic          out_uses_rd;
    logic          full;
    logic          early_full;
    logic [CW-1:0] count;

    instruction_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .push           (push),
        .in_instruction (in_instruction),
        .in_pc          (in_pc),
        .in_prediction  (in_prediction),
        .in_uses_rs1    (in_uses_rs1),
        .in_uses_rs2    (in_uses_rs2),
        .in_uses_rd     (in_uses_rd),
        .pop            (pop),
        .flush          (flush),
        .valid          (valid),
        .out_instruction(out_instruction),
        .out_pc         (out_pc),
        .out_prediction (out_prediction),
        .out_uses_rs1   (out_uses_rs1),
        .out_uses_rs2   (out_uses_rs2),
        .out_uses_rd    (out_uses_rd),
        .full           (full),
        .early_full     (early_full),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        pu;
        logic        po;
        logic        fl;
        logic [31:0] pc;
        logic [31:0] ins;
        int          cnt;
        logic        v;
        logic        f;
        logic        e;
    } vec_t;

    vec_t        vecs [$];
    logic [67:0] sb [$];
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [67:0] mk_entry(input logic [31:0] ins, input logic [31:0] pc);
        return {ins, pc, pc[2], pc[3], pc[4], pc[5]};
    endfunction

    function automatic vec_t v(input logic r, input logic pu, input logic po, input logic fl,
                               input logic [31:0] pc, input int cnt, input logic vv,
                               input logic ff, input logic ee);
        vec_t t;
        t.r = r; t.pu = pu; t.po = po; t.fl = fl; t.pc = pc;
        t.ins = pc ^ 32'hDEAD_0000;
        t.cnt = cnt; t.v = vv; t.f = ff; t.e = ee;
        return t;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive, check the popped head against the scoreboard, update the model.
    task automatic step(input logic r, input logic pu, input logic po, input logic fl,
                        input logic [31:0] pc, input logic [31:0] ins);
        logic pop_ok, push_ok;
        @(negedge clk);
        rst = r; push = pu; pop = po; flush = fl;
        in_pc = pc; in_instruction = ins;
        in_prediction = pc[2]; in_uses_rs1 = pc[3]; in_uses_rs2 = pc[4]; in_uses_rd = pc[5];
        pop_ok  = po && (sb.size() > 0);
        push_ok = pu && ((sb.size() < DEPTH) || pop_ok);
        #1;
        if (!r && !fl && pop_ok)
            check("head", {60'd0, out_instruction, out_pc, out_prediction, out_uses_rs1,
                           out_uses_rs2, out_uses_rd}, {60'd0, sb[0]});
        @(posedge clk);
        if (r || fl) begin
            sb.delete();
        end else begin
            if (pop_ok)  void'(sb.pop_front());
            if (push_ok) sb.push_back(mk_entry(ins, pc));
        end
        #1;
        rst = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0;
    endtask

    task automatic check_flags(input string name, input int cnt, input logic vv,
                               input logic ff, input logic ee);
        check(name, {124'd0, valid, full, early_full, 1'b0} | 128'(count) << 8,
                    {124'd0, vv, ff, ee, 1'b0} | 128'(cnt) << 8);
    endtask

    initial begin
        rst = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0;
        in_instruction = '0; in_pc = '0; in_prediction = 1'b0;
        in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0; in_uses_rd = 1'b0;

        //            rst push pop flush pc        cnt v  f  e
        vecs.push_back(v(1, 0, 0, 0, 32'h000, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 32'h000, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 32'h000, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 32'h100, 1, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 32'h104, 2, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 32'h108, 3, 1, 0, 1));
        vecs.push_back(v(0, 1, 0, 0, 32'h10C, 4, 1, 1, 1));
        vecs.push_back(v(0, 1, 0, 0, 32'h110, 4, 1, 1, 1));
        vecs.push_back(v(0, 0, 1, 0, 32'h000, 3, 1, 0, 1));
        vecs.push_back(v(0, 0, 1, 0, 32'h000, 2, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 32'h000, 1, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 32'h000, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 32'h114, 1, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 32'h118, 2, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 32'h11C, 3, 1, 0, 1));
        vecs.push_back(v(0, 1, 0, 0, 32'h120, 4, 1, 1, 1));
        vecs.push_back(v(0, 1, 1, 0, 32'h200, 4, 1, 1, 1));
        vecs.push_back(v(0, 0, 1, 0, 32'h000, 3, 1, 0, 1));
        vecs.push_back(v(0, 0, 1, 0, 32'h000, 2, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 32'h000, 1, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 32'h000, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 32'h500, 1, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 32'h504, 2, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 32'h508, 3, 1, 0, 1));
        vecs.push_back(v(0, 1, 0, 1, 32'h50C, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 32'h300, 1, 1, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].pu, vecs[i].po, vecs[i].fl, vecs[i].pc, vecs[i].ins);
            check_flags($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].v, vecs[i].f, vecs[i].e);
        end
        check("flush_head_pc", 128'(out_pc), 128'h300);
        step(0, 0, 1, 0, 32'h0, 32'h0);
        check_flags("after_flush_drain", 0, 0, 0, 0);

        // Push into an empty buffer together with a pop: only the push lands.
        step(0, 1, 1, 0, 32'h400, 32'h0000_0013);
        check_flags("empty_push_pop", 1, 1, 0, 0);
        check("empty_push_pop_instr", 128'(out_instruction), 128'h13);
        step(0, 0, 1, 0, 32'h0, 32'h0);
        check_flags("empty_push_pop_drain", 0, 0, 0, 0);

        // Random wrap-around stress against the queue model, reset mid-run.
        for (int i = 0; i < 40; i++) begin
            logic       r, pu, po;
            logic [31:0] pc;
            r  = (i == 20);
            pu = 1'($urandom_range(0, 99) < 60);
            po = 1'($urandom_range(0, 99) < 50);
            pc = 32'h1000 + 32'(i * 4);
            step(r, pu, po, 1'b0, pc, $urandom);
            check_flags($sformatf("rand%0d", i), sb.size(), sb.size() != 0,
                        sb.size() == DEPTH, sb.size() >= DEPTH - 1);
        end
        while (sb.size() > 0) step(0, 0, 1, 0, 32'h0, 32'h0);
        check_flags("final_empty", 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
